iob_native_ram_responder: RTL and testbench

- Responder (slave) end of the IOb native bus: the counterpart of the CPU-side initiator.
- Accepts one request at a time on the packed `REQ_W request bus and performs a byte-enabled read or write on an internal word RAM.
- Answers on the packed `RESP_W response bus with a single-cycle rvalid pulse after a programmable latency plus a dynamic stall.
- Sits on ibus/dbus as boot/scratch memory and as a bus-compliance target for CPU-wrapper verification.

---
 rtl/iob_native_ram_responder_pkg.sv | 25 ++
 rtl/iob_ram_sp_be.sv | 44 ++++
 rtl/iob_native_ram_responder.sv | 110 +++++++++++
 tb/tb_iob_native_ram_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_ram_responder_pkg.sv
// rtl/iob_native_ram_responder_pkg.sv - shared types, widths and bus layout helpers for the IOb native RAM responder
//
// Purpose : FSM state encoding, wait-counter width and the packed
//           request/response width helpers used by the responder and its bench.
// Layout  : req  = {avalid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
//           resp = {rdata[DATA_W], rvalid}
package iob_native_ram_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// rtl/iob_ram_sp_be.sv - single-port byte-enable RAM with registered read
//
// Purpose : word RAM; one access per enabled cycle. A write updates the
//           lanes selected by we; an enabled cycle with we==0 is a read whose
//           data appears on rdata after the clock edge.
// Ports   : clk   - clock
//           en    - access enable
//           we    - per-byte write enables (DATA_W/8)
//           addr  - word address
//           wdata - write data
//           rdata - registered read data
module iob_ram_sp_be
  import iob_native_ram_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset; the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (we[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      if (we == '0) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/iob_native_ram_responder.sv
// rtl/iob_native_ram_responder.sv - IOb native bus responder backed by a byte-enable word RAM
//
// Purpose : accepts one request at a time, performs a byte-enabled write
//           (wstrb!=0) or a read (wstrb==0) on an internal RAM and answers
//           with a one-cycle rvalid after 2+WAIT_CYCLES cycles plus stalls.
// Ports   : clk   - clock
//           rst   - asynchronous active-high reset
//           req   - packed request {avalid, address, wdata, wstrb}
//           resp  - packed response {rdata, rvalid}
//           stall - holds the FSM in WAIT while high
module iob_native_ram_responder
  import iob_native_ram_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [req_width(ADDR_W, DATA_W)-1:0] req,
  output logic [resp_width(DATA_W)-1:0]        resp,
  input  logic                                 stall
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = req_width(ADDR_W, DATA_W);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  logic              req_avalid;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  assign req_avalid  = req[REQ_W-1];
  assign req_address = req[STRB_W+DATA_W +: ADDR_W];
  assign req_wdata   = req[STRB_W +: DATA_W];
  assign req_wstrb   = req[0 +: STRB_W];

  // Only the word index of the address is stored; the rest aliases.
  logic unused_address_bits;
  assign unused_address_bits = ^req_address;

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic accept;
  logic wait_done;

  assign accept    = (state == ST_IDLE) && req_avalid;
  assign wait_done = (state == ST_WAIT) && (cnt == '0) && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_avalid) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_done)  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_address[2 +: MEM_ADDR_W];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt     <= WAIT_INIT;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The RAM is touched only on the WAIT exit edge, so an access aborted by
  // reset earlier never reaches memory, and the registered read lands in RESP.
  logic [DATA_W-1:0] ram_rdata;

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (wait_done),
    .we    (wstrb_q & {STRB_W{wait_done}}),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  assign rvalid = (state == ST_RESP);
  assign rdata  = (rvalid && (wstrb_q == '0)) ? ram_rdata : '0;
  assign resp   = {rdata, rvalid};

endmodule

// File: tb/tb_iob_native_ram_responder.sv
// tb/tb_iob_native_ram_responder.sv - directed self-checking bench for iob_native_ram_responder
module tb_iob_native_ram_responder;
  import iob_native_ram_responder_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = req_width(ADDR_W, DATA_W);
  localparam int RESP_W = resp_width(DATA_W);

  logic              clk;
  logic              rst;
  logic [REQ_W-1:0]  req   [2];
  logic [RESP_W-1:0] resp  [2];
  logic              stall [2];

  int compared;
  int mismatched;

  iob_native_ram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(10), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .resp(resp[0]), .stall(stall[0])
  );

  iob_native_ram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(10), .WAIT_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst(rst), .req(req[1]), .resp(resp[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int d, input logic av, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    req[d] = {av, a, wd, ws};
  endtask

  // Issues a request in the current cycle and follows it to rvalid.
  // Returns with the bench in the cycle after rvalid (back-to-back slot).
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int st_from, input int st_n,
                      input bit scramble, output int lat,
                      output logic [31:0] rd, output bit single);
    int k;
    bit got;
    k = 0; got = 0; lat = -1; rd = 32'hxxxx_xxxx; single = 0;
    set_req(d, 1'b1, a, wd, ws);
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      stall[d] = (k >= st_from) && (k < st_from + st_n);
      if (resp[d][0]) begin
        got = 1;
        lat = k;
        rd  = resp[d][DATA_W:1];
        stall[d] = 1'b0;
        set_req(d, 1'b0, 32'h0, 32'h0, 4'h0);
      end else if (scramble) begin
        set_req(d, 1'b1, ~a, $urandom, 4'(k));
      end else begin
        set_req(d, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    stall[d] = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      single = !resp[d][0];
    end
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; bit single;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 32'h0, 32'h0, 4'h0);
      stall[i] = 1'b0;
    end
    #2;
    compared++;
    if (resp[0] !== '0) begin
      mismatched++;
      $display("FAIL reset_resp0_async: got %h expected 0", resp[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (resp[0] !== '0) begin
      mismatched++;
      $display("FAIL reset_resp0: got %h expected 0", resp[0]);
    end
    compared++;
    if (resp[1] !== '0) begin
      mismatched++;
      $display("FAIL reset_resp3: got %h expected 0", resp[1]);
    end
    rst = 1'b0;
    xact(0, 32'h100, 32'h0123_4567, 4'hF, 99, 0, 0, lat, rd, single);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL reset_release_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; bit single;
    xact(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 99, 0, 0, lat, rd, single);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL write_latency: got %0d expected 2", lat);
    end
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL write_rdata: got %h expected 00000000", rd);
    end
    compared++;
    if (single !== 1'b1) begin
      mismatched++;
      $display("FAIL write_rvalid_width: got %0d expected 1", single);
    end
    xact(0, 32'h10, 32'h0, 4'h0, 99, 0, 0, lat, rd, single);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL read_latency: got %0d expected 2", lat);
    end
    compared++;
    if (rd !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL read_rdata: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_strobes();
    int lat; logic [31:0] rd; bit single;
    xact(0, 32'h20, 32'h1122_3344, 4'hF, 99, 0, 0, lat, rd, single);
    xact(0, 32'h20, 32'hAABB_CCDD, 4'h5, 99, 0, 0, lat, rd, single);
    xact(0, 32'h20, 32'h0, 4'h0, 99, 0, 0, lat, rd, single);
    compared++;
    if (rd !== 32'h11BB_33DD) begin
      mismatched++;
      $display("FAIL strobe_merge: got %h expected 11bb33dd", rd);
    end
    xact(0, 32'h22, 32'h0000_7700, 4'h2, 99, 0, 0, lat, rd, single);
    xact(0, 32'h23, 32'h0, 4'h0, 99, 0, 0, lat, rd, single);
    compared++;
    if (rd !== 32'h11BB_77DD) begin
      mismatched++;
      $display("FAIL strobe_lane1_lowbits: got %h expected 11bb77dd", rd);
    end
  endtask

  task automatic test_latency_stall();
    int lat; logic [31:0] rd; bit single;
    xact(1, 32'h30, 32'hA5A5_5A5A, 4'hF, 99, 0, 0, lat, rd, single);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL wait3_write_latency: got %0d expected 5", lat);
    end
    xact(1, 32'h30, 32'h0, 4'h0, 99, 0, 0, lat, rd, single);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL wait3_read_latency: got %0d expected 5", lat);
    end
    compared++;
    if (rd !== 32'hA5A5_5A5A) begin
      mismatched++;
      $display("FAIL wait3_read_rdata: got %h expected a5a55a5a", rd);
    end
    compared++;
    if (single !== 1'b1) begin
      mismatched++;
      $display("FAIL wait3_rvalid_width: got %0d expected 1", single);
    end
    xact(1, 32'h30, 32'h0, 4'h0, 4, 2, 0, lat, rd, single);
    compared++;
    if (lat !== 7) begin
      mismatched++;
      $display("FAIL stall_latency: got %0d expected 7", lat);
    end
    compared++;
    if (rd !== 32'hA5A5_5A5A) begin
      mismatched++;
      $display("FAIL stall_rdata: got %h expected a5a55a5a", rd);
    end
    compared++;
    if (single !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_rvalid_width: got %0d expected 1", single);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; bit single;
    xact(0, 32'h0, 32'hCAFE_F00D, 4'hF, 99, 0, 0, lat, rd, single);
    xact(0, 32'h1000, 32'h0, 4'h0, 99, 0, 1, lat, rd, single);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL b2b_latency: got %0d expected 2", lat);
    end
    compared++;
    if (rd !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL b2b_alias_rdata: got %h expected cafef00d", rd);
    end
    xact(1, 32'h0, 32'h0, 4'h0, 99, 0, 1, lat, rd, single);
    xact(1, 32'h30, 32'h0, 4'h0, 99, 0, 1, lat, rd, single);
    compared++;
    if (rd !== 32'hA5A5_5A5A || lat !== 5) begin
      mismatched++;
      $display("FAIL wait3_scramble: got %h lat %0d expected a5a55a5a lat 5", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; bit single;
    int seen;
    xact(0, 32'h40, 32'h0, 4'hF, 99, 0, 0, lat, rd, single);
    // write aborted while in WAIT
    set_req(0, 1'b1, 32'h40, 32'h5555_5555, 4'hF);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (resp[0] !== '0) begin
      mismatched++;
      $display("FAIL abort_wait_resp: got %h expected 0", resp[0]);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp[0][0]) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL abort_wait_no_rvalid: got %0d rvalid cycles expected 0", seen);
    end
    xact(0, 32'h40, 32'h0, 4'h0, 99, 0, 0, lat, rd, single);
    compared++;
    if (rd !== 32'h0 || lat !== 2) begin
      mismatched++;
      $display("FAIL abort_wait_ram: got %h lat %0d expected 00000000 lat 2", rd, lat);
    end
    // read aborted in its rvalid cycle
    set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    compared++;
    if (resp[0] !== {32'hDEAD_BEEF, 1'b1}) begin
      mismatched++;
      $display("FAIL pre_abort_resp: got %h expected %h", resp[0], {32'hDEAD_BEEF, 1'b1});
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (resp[0] !== '0) begin
      mismatched++;
      $display("FAIL abort_resp_resp: got %h expected 0", resp[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp[0][0]) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL abort_resp_no_rvalid: got %0d rvalid cycles expected 0", seen);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_write_read();
    test_strobes();
    test_latency_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
